// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: groups the scan-enable, column sense, row drive and key
// event outputs of the 4x4 keypad scanner. The master side drives tick and
// col_in; the slave side (the scanner) drives the row and key outputs.
interface keypad_scanner_if;
    logic       tick;
    logic [3:0] col_in;
    logic [3:0] row_out;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (
        output tick,
        output col_in,
        input  row_out,
        input  key_valid,
        input  key_code,
        input  key_held
    );

    modport slave (
        input  tick,
        input  col_in,
        output row_out,
        output key_valid,
        output key_code,
        output key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
// Rows are driven active-low one at a time; columns are sensed active-low.
// State only advances on cycles where tick=1. A press is accepted after
// DEBOUNCE_SCANS qualifying ticks and reported as a one-clock key_valid pulse
// with key_code = row*4 + col; key_held stays high until the release has been
// debounced. Only the first detected key is tracked until it is released.
// Optional feature: define KEYPAD_REPEAT_EN to add auto-repeat, which emits an
// extra key_valid every REPEAT_TICKS ticks while the key stays pressed.
module keypad_scanner #(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_TICKS   = 500
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.slave  kp
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_SCANS must be at least 1");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_TICKS must be at least 1");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       row, row_nxt;
    logic [1:0]       col_sel, col_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       key_code_r, code_nxt;
    logic             key_valid_r, valid_nxt;
    logic             col_hi;

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
    logic [RPT_W-1:0] rpt_cnt, rpt_nxt;
`endif

    // Saturating debounce count: once at DEBOUNCE_SCANS it stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_ONE;
    endfunction

    // Index of the lowest-numbered column that reads low (pressed).
    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    assign col_hi = kp.col_in[col_sel];

    // Next-state and event logic; nothing moves unless tick is high.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col_sel;
        cnt_nxt   = cnt;
        code_nxt  = key_code_r;
        valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_nxt   = rpt_cnt;
`endif
        if (kp.tick) begin
            case (state)
                SCAN: begin
                    if (&kp.col_in) begin
                        row_nxt = row + 2'd1;
                    end else begin
                        col_nxt   = lowest_low(kp.col_in);
                        cnt_nxt   = CNT_ONE;
                        state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!col_hi) begin
                        cnt_nxt = sat_inc(cnt);
                        if (sat_inc(cnt) == CNT_MAX) begin
                            state_nxt = PRESSED;
                            valid_nxt = 1'b1;
                            code_nxt  = {row, col_sel};
`ifdef KEYPAD_REPEAT_EN
                            rpt_nxt   = '0;
`endif
                        end
                    end else begin
                        state_nxt = SCAN;
                        row_nxt   = row + 2'd1;
                    end
                end
                PRESSED: begin
                    if (col_hi) begin
                        cnt_nxt   = CNT_ONE;
                        state_nxt = RELEASE;
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rpt_cnt == RPT_LAST) begin
                            rpt_nxt   = '0;
                            valid_nxt = 1'b1;
                        end else begin
                            rpt_nxt = rpt_cnt + 1'b1;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (col_hi) begin
                        cnt_nxt = sat_inc(cnt);
                        if (sat_inc(cnt) == CNT_MAX) begin
                            state_nxt = SCAN;
                            row_nxt   = row + 2'd1;
                        end
                    end else begin
                        // Bounce back to pressed: same key, no new event, and
                        // the repeat count resumes where it paused.
                        state_nxt = PRESSED;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            row         <= 2'd0;
            cnt         <= '0;
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt     <= '0;
`endif
        end else begin
            state       <= state_nxt;
            row         <= row_nxt;
            cnt         <= cnt_nxt;
            key_code_r  <= code_nxt;
            key_valid_r <= valid_nxt;
`ifdef KEYPAD_REPEAT_EN
            rpt_cnt     <= rpt_nxt;
`endif
        end
    end

    // Latched column of the key being tracked; only read after SCAN loads it.
    always_ff @(posedge clk) begin
        col_sel <= col_nxt;
    end

    assign kp.row_out   = ~(4'b0001 << row);
    assign kp.key_valid = key_valid_r;
    assign kp.key_code  = key_code_r;
    assign kp.key_held  = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed vector table, hand-written corner sequences and
// a randomized keypad run checked against a behavioural model of the scanner.
module tb_keypad_scanner;

    localparam int DS   = 4;
    localparam int RT   = 3;
    localparam int NEED = (DS < 2) ? 2 : DS;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_RPT = 3;
`else
    localparam int EXP_RPT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if ifc ();
    keypad_scanner_if ifc1 ();

    keypad_scanner #(.DEBOUNCE_SCANS(DS), .REPEAT_TICKS(RT)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (ifc)
    );

    keypad_scanner #(.DEBOUNCE_SCANS(1), .REPEAT_TICKS(RT)) dut1 (
        .clk (clk),
        .rst (rst),
        .kp  (ifc1)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] s_row, s_code, i_row;
    logic       s_v, s_held, i_v, i_held;

    typedef struct {
        bit         rst_before;
        logic [3:0] col;
        logic [3:0] row;
        bit         v;
        logic [3:0] code;
        bit         held;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input bit r, input logic [3:0] c, input logic [3:0] rw,
                                input bit v, input logic [3:0] code, input bit h);
        vec_t e;
        e.rst_before = r; e.col = c; e.row = rw; e.v = v; e.code = code; e.held = h;
        tbl.push_back(e);
    endfunction

    // Reset with tick asserted and col_in given, so reset must win over tick.
    task automatic do_reset(input logic [3:0] c);
        @(negedge clk);
        rst = 1'b1; ifc.tick = 1'b1; ifc.col_in = c; ifc1.tick = 1'b1; ifc1.col_in = c;
        @(negedge clk);
        rst = 1'b0; ifc.tick = 1'b0; ifc1.tick = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_row"},   ifc.row_out,   4'b1110);
        chk({tag, "_valid"}, ifc.key_valid, 0);
        chk({tag, "_code"},  ifc.key_code,  0);
        chk({tag, "_held"},  ifc.key_held,  0);
    endtask

    // One tick cycle on the main DUT, then one idle cycle with scrambled columns.
    task automatic step(input logic [3:0] c);
        @(negedge clk);
        ifc.tick = 1'b1; ifc.col_in = c;
        @(negedge clk);
        ifc.tick = 1'b0; ifc.col_in = 4'($urandom);
        s_row = ifc.row_out; s_v = ifc.key_valid; s_code = ifc.key_code; s_held = ifc.key_held;
        @(negedge clk);
        i_row = ifc.row_out; i_v = ifc.key_valid; i_held = ifc.key_held;
    endtask

    task automatic step1(input logic [3:0] c);
        @(negedge clk);
        ifc1.tick = 1'b1; ifc1.col_in = c;
        @(negedge clk);
        ifc1.tick = 1'b0; ifc1.col_in = 4'hF;
        s_row = ifc1.row_out; s_v = ifc1.key_valid; s_code = ifc1.key_code; s_held = ifc1.key_held;
    endtask

    // Behavioural model: tracks runs of consecutive low/high ticks on the
    // candidate key instead of an explicit state encoding. A key is accepted
    // once it has read low on NEED consecutive ticks counted from detection,
    // and released once it has read high on NEED consecutive ticks.
    int m_row, m_cand, m_code, m_low, m_high, m_rep;
    bit m_acc;

    function automatic void model_reset();
        m_row = 0; m_cand = -1; m_code = 0; m_low = 0; m_high = 0; m_rep = 0; m_acc = 0;
    endfunction

    function automatic bit model_tick(input logic [3:0] c);
        bit ev = 0;
        if (m_cand < 0) begin
            if (c == 4'hF) m_row = (m_row + 1) % 4;
            else begin
                for (int k = 3; k >= 0; k--) if (!c[k]) m_cand = k;
                m_low = 1;
            end
        end else if (!m_acc) begin
            if (!c[m_cand]) begin
                m_low++;
                if (m_low >= NEED) begin
                    m_acc = 1; ev = 1; m_code = m_row * 4 + m_cand; m_rep = 0; m_high = 0;
                end
            end else begin
                m_cand = -1; m_row = (m_row + 1) % 4;
            end
        end else begin
            if (!c[m_cand]) begin
                if (m_high > 0) m_high = 0;
                else begin
`ifdef KEYPAD_REPEAT_EN
                    m_rep++;
                    if (m_rep == RT) begin m_rep = 0; ev = 1; end
`endif
                end
            end else begin
                m_high++;
                if (m_high >= NEED) begin
                    m_acc = 0; m_cand = -1; m_row = (m_row + 1) % 4;
                end
            end
        end
        return ev;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [15:0] mask, cur;
        logic [3:0]  c, er;
        bit          ev;

        ifc.tick = 1'b0; ifc.col_in = 4'hF; ifc1.tick = 1'b0; ifc1.col_in = 4'hF;

        // Idle scan of 8 ticks
        add(1, 4'hF, 4'b1101, 0, 0, 0); add(0, 4'hF, 4'b1011, 0, 0, 0);
        add(0, 4'hF, 4'b0111, 0, 0, 0); add(0, 4'hF, 4'b1110, 0, 0, 0);
        add(0, 4'hF, 4'b1101, 0, 0, 0); add(0, 4'hF, 4'b1011, 0, 0, 0);
        add(0, 4'hF, 4'b0111, 0, 0, 0); add(0, 4'hF, 4'b1110, 0, 0, 0);
        // Two-tick glitch on row 0 / column 3
        add(0, 4'b0111, 4'b1110, 0, 0, 0); add(0, 4'b0111, 4'b1110, 0, 0, 0);
        add(0, 4'hF, 4'b1101, 0, 0, 0);    add(0, 4'hF, 4'b1011, 0, 0, 0);
        // Row 2 / column 1 press, bounce on release, final release
        for (int i = 0; i < 3; i++) add(0, 4'b1101, 4'b1011, 0, 0, 0);
        add(0, 4'b1101, 4'b1011, 1, 9, 1); add(0, 4'b1101, 4'b1011, 0, 9, 1);
        add(0, 4'hF, 4'b1011, 0, 9, 1);    add(0, 4'hF, 4'b1011, 0, 9, 1);
        add(0, 4'b1101, 4'b1011, 0, 9, 1);
        for (int i = 0; i < 3; i++) add(0, 4'hF, 4'b1011, 0, 9, 1);
        add(0, 4'hF, 4'b0111, 0, 9, 0);    add(0, 4'hF, 4'b1110, 0, 9, 0);
        // Row 1, columns 0 and 2 together; column 2 activity ignored
        add(0, 4'hF, 4'b1101, 0, 9, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1010, 4'b1101, 0, 9, 0);
        add(0, 4'b1010, 4'b1101, 1, 4, 1); add(0, 4'b1110, 4'b1101, 0, 4, 1);
        add(0, 4'b1010, 4'b1101, 0, 4, 1);
        for (int i = 0; i < 3; i++) add(0, 4'b1011, 4'b1101, 0, 4, 1);
        add(0, 4'b1011, 4'b1011, 0, 4, 0);
        add(0, 4'hF, 4'b0111, 0, 4, 0); add(0, 4'hF, 4'b1110, 0, 4, 0);
        add(0, 4'hF, 4'b1101, 0, 4, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1011, 4'b1101, 0, 4, 0);
        add(0, 4'b1011, 4'b1101, 1, 6, 1);
        // Reset while pressed, key re-detected as a new press
        add(1, 4'hF, 4'b1101, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 4'b1011, 4'b1101, 0, 0, 0);
        add(0, 4'b1011, 4'b1101, 1, 6, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) begin
                do_reset(4'h0);
                chk_reset($sformatf("tbl%0d_rst", i));
            end
            step(tbl[i].col);
            chk($sformatf("tbl%0d_row", i),   s_row,  tbl[i].row);
            chk($sformatf("tbl%0d_valid", i), s_v,    tbl[i].v);
            chk($sformatf("tbl%0d_code", i),  s_code, tbl[i].code);
            chk($sformatf("tbl%0d_held", i),  s_held, tbl[i].held);
            chk($sformatf("tbl%0d_idle_valid", i), i_v,    0);
            chk($sformatf("tbl%0d_idle_row", i),   i_row,  tbl[i].row);
            chk($sformatf("tbl%0d_idle_held", i),  i_held, tbl[i].held);
        end

        // Reset during DEBOUNCE: no event, debounce restarts from scratch
        do_reset(4'hF);
        step(4'b1110); step(4'b1110);
        do_reset(4'b1110);
        chk_reset("dbrst");
        pulses = 0;
        for (int i = 0; i < 3; i++) begin step(4'b1110); pulses += int'(s_v); end
        chk("dbrst_early_pulses", pulses, 0);
        step(4'b1110);
        chk("dbrst_accept_valid", s_v, 1);
        chk("dbrst_accept_code", s_code, 0);

        // DEBOUNCE_SCANS=1 instance: accept on the tick after detection
        do_reset(4'hF);
        step1(4'hF);    chk("ds1_scan_row", s_row, 4'b1101);
        step1(4'b1011); chk("ds1_detect_valid", s_v, 0); chk("ds1_detect_held", s_held, 0);
        step1(4'b1011); chk("ds1_accept_valid", s_v, 1); chk("ds1_accept_code", s_code, 6);
        chk("ds1_accept_held", s_held, 1);
        step1(4'hF);    chk("ds1_rel1_held", s_held, 1);
        step1(4'hF);    chk("ds1_rel2_held", s_held, 0); chk("ds1_rel2_row", s_row, 4'b1011);

        // Hold key 0 for 10 ticks after acceptance, then reset mid-hold
        do_reset(4'hF);
        for (int i = 0; i < 4; i++) step(4'b1110);
        chk("rpt_accept_valid", s_v, 1);
        chk("rpt_accept_code", s_code, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b1110);
            if (s_v) begin pulses++; chk("rpt_pulse_code", s_code, 0); end
        end
        chk("rpt_count", pulses, EXP_RPT);
        do_reset(4'b1110);
        chk_reset("rpt_rst");
        pulses = 0;
        for (int i = 0; i < 3; i++) begin step(4'b1110); pulses += int'(s_v); end
        chk("rpt_after_rst_pulses", pulses, 0);
        chk("rpt_after_rst_held", s_held, 0);

        // Randomized keypad activity against the model
        do_reset(4'hF);
        model_reset();
        mask = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(9))
                    0, 1, 2, 3, 4: mask = '0;
                    5, 6, 7:       mask = 16'(1) << $urandom_range(15);
                    default:       mask = (16'(1) << $urandom_range(15)) | (16'(1) << $urandom_range(15));
                endcase
            end
            cur = mask;
            if ($urandom_range(15) == 0) cur = cur ^ (16'(1) << $urandom_range(15));
            c = ~cur[m_row*4 +: 4];
            ev = model_tick(c);
            er = ~(4'b0001 << m_row);
            step(c);
            chk("rnd_row",   s_row,  er);
            chk("rnd_valid", s_v,    ev);
            chk("rnd_code",  s_code, m_code);
            chk("rnd_held",  s_held, m_acc);
            chk("rnd_idle_valid", i_v, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
